// File: rtl/pi_gpio_pkg.sv
// rtl/pi_gpio_pkg.sv - shared constants and byte-lane helpers for the Pi GPIO register block
package pi_gpio_pkg;

  // Header pin count
  localparam int GPIO_W = 28;

  // Base addresses of the four 32-bit register groups
  localparam logic [7:0] PI_GPIO_OE   = 8'h90;
  localparam logic [7:0] PI_GPIO_EDGE = 8'h94;
  localparam logic [7:0] PI_GPIO_DATA = 8'h98;
  localparam logic [7:0] PI_GPIO_IEN  = 8'h9C;

  // One-hot byte-lane select from address bits [1:0]
  function automatic logic [3:0] lane_sel(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

  // Extract the addressed little-endian byte of a 32-bit group
  function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/pi_gpio_sync.sv
// rtl/pi_gpio_sync.sv - pin input synchronizer, history flop and registered edge detect
module pi_gpio_sync #(
  parameter int W      = 28,
  parameter int STAGES = 2
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_sync,
  output logic [W-1:0] o_edge
);

  logic [W-1:0] r_sync [STAGES];
  logic [W-1:0] r_hist;
  logic [W-1:0] r_edge;

  // Synchronizer chain, history flop and edge register; edges are suppressed
  // while i_en is low so the post-reset fill of the chain never looks like a pin edge
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int s = 0; s < STAGES; s++) r_sync[s] <= '0;
      r_hist <= '0;
      r_edge <= '0;
    end else begin
      r_sync[0] <= i_d;
      for (int s = 1; s < STAGES; s++) r_sync[s] <= r_sync[s-1];
      r_hist <= r_sync[STAGES-1];
      r_edge <= i_en ? (r_sync[STAGES-1] ^ r_hist) : '0;
    end
  end

  assign o_sync = r_sync[STAGES-1];
  assign o_edge = r_edge;

endmodule

// File: rtl/pi_gpio_regs.sv
// rtl/pi_gpio_regs.sv - register-mapped GPIO controller with edge capture and level interrupt
module pi_gpio_regs #(
  parameter int GPIO_W      = 28,
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [7:0]        i_reg_addr,
  input  logic              i_reg_wr,
  input  logic [7:0]        i_reg_wdata,
  input  logic              i_reg_rd,
  output logic [7:0]        o_reg_rdata,
  output logic              o_reg_rvalid,
  output logic              o_reg_hit,
  output logic [GPIO_W-1:0] o_gpio_o,
  output logic [GPIO_W-1:0] o_gpio_t,
  input  logic [GPIO_W-1:0] i_gpio_i,
  output logic              o_irq
);

  import pi_gpio_pkg::*;

  localparam logic [1:0] ARM_LAST = 2'(SYNC_STAGES);

  logic [GPIO_W-1:0] r_oe;
  logic [GPIO_W-1:0] r_out_data;
  logic [GPIO_W-1:0] r_edge_status;
  logic [GPIO_W-1:0] r_edge_en;
  logic              r_irq;
  logic [7:0]        r_rdata;
  logic              r_rvalid;
  logic [1:0]        r_arm_cnt;
  logic              r_armed;

  logic              w_hit;
  logic [3:0]        w_lane_sel;
  logic [GPIO_W-1:0] w_mask;
  logic [GPIO_W-1:0] w_wdata;
  logic [GPIO_W-1:0] w_clr;
  logic [GPIO_W-1:0] w_sync;
  logic [GPIO_W-1:0] w_edge;
  logic [31:0]       w_rd_word;
  logic              w_wr_oe;
  logic              w_wr_edge;
  logic              w_wr_data;
  logic              w_wr_ien;

  assign w_hit      = (i_reg_addr[7:4] == PI_GPIO_OE[7:4]);
  assign w_lane_sel = lane_sel(i_reg_addr[1:0]);

  // Replicate the write byte across the group and build the per-pin lane mask
  for (genvar g = 0; g < GPIO_W; g++) begin : g_lane
    assign w_mask[g]  = w_lane_sel[g/8];
    assign w_wdata[g] = i_reg_wdata[g%8];
  end

  assign w_wr_oe   = i_reg_wr && w_hit && (i_reg_addr[3:2] == PI_GPIO_OE[3:2]);
  assign w_wr_edge = i_reg_wr && w_hit && (i_reg_addr[3:2] == PI_GPIO_EDGE[3:2]);
  assign w_wr_data = i_reg_wr && w_hit && (i_reg_addr[3:2] == PI_GPIO_DATA[3:2]);
  assign w_wr_ien  = i_reg_wr && w_hit && (i_reg_addr[3:2] == PI_GPIO_IEN[3:2]);
  assign w_clr     = w_wr_edge ? (w_wdata & w_mask) : '0;

  pi_gpio_sync #(
    .W      (GPIO_W),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    (r_armed),
    .i_d     (i_gpio_i),
    .o_sync  (w_sync),
    .o_edge  (w_edge)
  );

  // Arming holdoff: count out the synchronizer fill after reset before trusting edges
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_arm_cnt <= '0;
      r_armed   <= 1'b0;
    end else if (!r_armed) begin
      if (r_arm_cnt == ARM_LAST) r_armed <= 1'b1;
      else                       r_arm_cnt <= r_arm_cnt + 2'd1;
    end
  end

  // Register file; a new edge wins over a same-cycle W1C on the same bit
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_oe          <= '0;
      r_out_data    <= '0;
      r_edge_status <= '0;
      r_edge_en     <= '0;
      r_irq         <= 1'b0;
    end else begin
      if (w_wr_oe)   r_oe       <= (r_oe & ~w_mask) | (w_wdata & w_mask);
      if (w_wr_data) r_out_data <= (r_out_data & ~w_mask) | (w_wdata & w_mask);
      if (w_wr_ien)  r_edge_en  <= (r_edge_en & ~w_mask) | (w_wdata & w_mask);
      r_edge_status <= (r_edge_status & ~w_clr) | w_edge;
      r_irq         <= |(r_edge_status & r_edge_en);
    end
  end

  // Read source select; the data group reads the synchronized pins, not out_data
  always_comb begin
    w_rd_word = '0;
    case (i_reg_addr[3:2])
      2'd0:    w_rd_word = 32'(r_oe);
      2'd1:    w_rd_word = 32'(r_edge_status);
      2'd2:    w_rd_word = 32'(w_sync);
      default: w_rd_word = 32'(r_edge_en);
    endcase
  end

  // Registered read port; data is captured from pre-write state and held until the next read
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rdata  <= 8'h00;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= i_reg_rd;
      if (i_reg_rd) r_rdata <= w_hit ? lane_byte(w_rd_word, i_reg_addr[1:0]) : 8'h00;
    end
  end

  assign o_reg_hit    = w_hit;
  assign o_reg_rdata  = r_rdata;
  assign o_reg_rvalid = r_rvalid;
  assign o_gpio_o     = r_out_data;
  assign o_gpio_t     = ~r_oe;
  assign o_irq        = r_irq;

endmodule

// File: tb/tb_pi_gpio_regs.sv
// tb/tb_pi_gpio_regs.sv - directed self-checking bench for pi_gpio_regs
module tb_pi_gpio_regs;

  localparam int W = 28;
  localparam int S = 2;

  logic         clk;
  logic         reset;
  logic [7:0]   reg_addr;
  logic         reg_wr;
  logic [7:0]   reg_wdata;
  logic         reg_rd;
  logic [7:0]   reg_rdata;
  logic         reg_rvalid;
  logic         reg_hit;
  logic [W-1:0] gpio_o;
  logic [W-1:0] gpio_t;
  logic [W-1:0] gpio_i;
  logic         irq;

  int checks = 0;
  int errors = 0;

  pi_gpio_regs #(
    .GPIO_W      (W),
    .SYNC_STAGES (S)
  ) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_reg_addr   (reg_addr),
    .i_reg_wr     (reg_wr),
    .i_reg_wdata  (reg_wdata),
    .i_reg_rd     (reg_rd),
    .o_reg_rdata  (reg_rdata),
    .o_reg_rvalid (reg_rvalid),
    .o_reg_hit    (reg_hit),
    .o_gpio_o     (gpio_o),
    .o_gpio_t     (gpio_t),
    .i_gpio_i     (gpio_i),
    .o_irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    reg_addr  = a;
    reg_wdata = d;
    reg_wr    = 1'b1;
    @(negedge clk);
    reg_wr    = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string tag);
    reg_addr = a;
    reg_rd   = 1'b1;
    @(negedge clk);
    reg_rd   = 1'b0;
    check({tag, " rvalid"}, 32'(reg_rvalid), 32'd1);
    check({tag, " rdata"}, 32'(reg_rdata), 32'(exp));
  endtask

  initial begin
    reset     = 1'b1;
    reg_addr  = 8'h00;
    reg_wr    = 1'b0;
    reg_wdata = 8'h00;
    reg_rd    = 1'b0;
    gpio_i    = '0;
    repeat (3) @(negedge clk);

    check("reset gpio_t", 32'(gpio_t), 32'h0FFFFFFF);
    check("reset gpio_o", 32'(gpio_o), 32'h0);
    check("reset irq", 32'(irq), 32'h0);
    check("reset rvalid", 32'(reg_rvalid), 32'h0);
    check("reset rdata", 32'(reg_rdata), 32'h0);
    reset = 1'b0;

    for (int a = 8'h90; a <= 8'h9F; a++) begin
      reg_addr = 8'(a);
      #1;
      check($sformatf("hit 0x%0h", a), 32'(reg_hit), 32'd1);
      rd(8'(a), 8'h00, $sformatf("reset read 0x%0h", a));
    end
    @(negedge clk);
    check("rvalid drops", 32'(reg_rvalid), 32'd0);

    wr(8'h93, 8'hFF);
    check("oe top byte gpio_t", 32'(gpio_t), 32'h00FFFFFF);
    wr(8'h9B, 8'hA5);
    check("out top byte gpio_o", 32'(gpio_o), 32'h05000000);
    rd(8'h93, 8'h0F, "read oe 0x93");
    rd(8'h9B, 8'h00, "read pins 0x9B");
    wr(8'h91, 8'h3C);
    check("oe lane1 gpio_t", 32'(gpio_t), 32'h00FFC3FF);
    wr(8'hA0, 8'hFF);
    check("miss write ignored", 32'(gpio_t), 32'h00FFC3FF);

    reg_addr  = 8'h90;
    reg_wdata = 8'h11;
    reg_wr    = 1'b1;
    reg_rd    = 1'b1;
    @(negedge clk);
    reg_wr    = 1'b0;
    reg_rd    = 1'b0;
    check("rd+wr rvalid", 32'(reg_rvalid), 32'd1);
    check("rd+wr old data", 32'(reg_rdata), 32'h00);
    check("rd+wr gpio_t", 32'(gpio_t), 32'h00FFC3EE);
    rd(8'h90, 8'h11, "read after rd+wr");

    wr(8'h9C, 8'h20);
    gpio_i[5] = 1'b1;
    repeat (S + 2) @(negedge clk);
    check("irq before edge latency", 32'(irq), 32'd0);
    @(negedge clk);
    check("irq after edge latency", 32'(irq), 32'd1);
    rd(8'h94, 8'h20, "status 0x94");
    rd(8'h98, 8'h20, "pins 0x98");
    rd(8'h9C, 8'h20, "ien 0x9C");

    gpio_i[5] = 1'b0;
    repeat (S + 1) @(negedge clk);
    wr(8'h94, 8'h20);
    check("w1c race irq", 32'(irq), 32'd1);
    @(negedge clk);
    check("w1c race irq held", 32'(irq), 32'd1);
    rd(8'h94, 8'h20, "w1c race status");

    wr(8'h94, 8'h20);
    check("w1c irq lag", 32'(irq), 32'd1);
    @(negedge clk);
    check("w1c irq falls", 32'(irq), 32'd0);
    rd(8'h94, 8'h00, "w1c cleared status");

    gpio_i[5] = 1'b1;
    repeat (S + 3) @(negedge clk);
    check("pre-reset irq", 32'(irq), 32'd1);
    rd(8'h94, 8'h20, "pre-reset status");

    gpio_i = 28'hFFFFFFF;
    reset  = 1'b1;
    @(negedge clk);
    check("mid reset gpio_t", 32'(gpio_t), 32'h0FFFFFFF);
    check("mid reset gpio_o", 32'(gpio_o), 32'h0);
    check("mid reset irq", 32'(irq), 32'h0);
    check("mid reset rdata", 32'(reg_rdata), 32'h0);
    check("mid reset rvalid", 32'(reg_rvalid), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    for (int a = 8'h94; a <= 8'h97; a++)
      rd(8'(a), 8'h00, $sformatf("arming status 0x%0h", a));
    rd(8'h9B, 8'h0F, "pins high 0x9B");
    rd(8'h98, 8'hFF, "pins high 0x98");

    wr(8'h9C, 8'h01);
    gpio_i[0] = 1'b0;
    repeat (S + 3) @(negedge clk);
    check("armed toggle irq", 32'(irq), 32'd1);
    rd(8'h94, 8'h01, "armed toggle status");

    reg_addr = 8'hA0;
    #1;
    check("miss hit", 32'(reg_hit), 32'd0);
    rd(8'hA0, 8'h00, "miss read 0xA0");
    @(negedge clk);
    check("miss rvalid drops", 32'(reg_rvalid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
